// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state
// encodings and default timing constants for a 100 MHz clock.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_HI = 2'd1,
      ST_HELD    = 2'd2,
      ST_WAIT_LO = 2'd3
   } btn_state_t;

   // 10 ms debounce window at 100 MHz
   localparam int unsigned DEF_DEB_CYCLES = 1000000;
   localparam int unsigned DEF_CNT_W      = 20;
   // 500 ms before first repeat, 100 ms between repeats at 100 MHz
   // (CNT_W must be widened when auto-repeat is enabled with these values)
   localparam int unsigned DEF_REP_DELAY  = 50000000;
   localparam int unsigned DEF_REP_PERIOD = 10000000;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Generic two-flop synchronizer for a single raw asynchronous input.
// Both stages reset asynchronously to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   // Shift the raw input through two flops to resolve metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes a raw button, debounces it with a
// four-state FSM and produces a clean level plus one-cycle press/release
// pulses. All outputs are registered.
// Optional feature: define BTN_AUTOREPEAT_EN to emit repeated press pulses
// while the button stays held.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
   parameter int unsigned REP_PERIOD = DEF_REP_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_CYCLES - 1);

   logic             w_s2;
   btn_state_t       r_state;
   btn_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_level;
   logic             w_level_nxt;
   logic             r_press;
   logic             w_press_nxt;
   logic             r_release;
   logic             w_release_nxt;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_D_TERM = CNT_W'(REP_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_P_TERM = CNT_W'(REP_PERIOD - 1);

   // r_rep_armed: the first (long) delay has elapsed, use the period next
   logic [CNT_W-1:0] r_rcnt;
   logic [CNT_W-1:0] w_rcnt_nxt;
   logic             r_rep_armed;
   logic             w_rep_armed_nxt;
   logic             w_rep_hit;

   assign w_rep_hit = r_rep_armed ? (r_rcnt == REP_P_TERM) : (r_rcnt == REP_D_TERM);
`else
   // Repeat timing is not used in this build
   logic w_unused_rep;
   assign w_unused_rep = ^{REP_DELAY, REP_PERIOD};
`endif

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (btn_in),
      .o_q   (w_s2)
   );

   // Register FSM state, counters and the registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_level     <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         r_rcnt      <= '0;
         r_rep_armed <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_level     <= w_level_nxt;
         r_press     <= w_press_nxt;
         r_release   <= w_release_nxt;
`ifdef BTN_AUTOREPEAT_EN
         r_rcnt      <= w_rcnt_nxt;
         r_rep_armed <= w_rep_armed_nxt;
`endif
      end
   end

   // Next-state, counter and output decode; terminal compare precedes
   // increment so the debounce counter can never wrap
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_level_nxt     = r_level;
      w_press_nxt     = 1'b0;
      w_release_nxt   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      w_rcnt_nxt      = r_rcnt;
      w_rep_armed_nxt = r_rep_armed;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_s2) begin
               w_state_nxt = ST_WAIT_HI;
               w_cnt_nxt   = '0;
            end
         end
         ST_WAIT_HI: begin
            if (!w_s2) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == DEB_TERM) begin
               w_state_nxt     = ST_HELD;
               w_level_nxt     = 1'b1;
               w_press_nxt     = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
               w_rcnt_nxt      = '0;
               w_rep_armed_nxt = 1'b0;
`endif
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_HELD: begin
            if (!w_s2) begin
               w_state_nxt = ST_WAIT_LO;
               w_cnt_nxt   = '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (w_rep_hit) begin
               w_press_nxt     = 1'b1;
               w_rcnt_nxt      = '0;
               w_rep_armed_nxt = 1'b1;
            end else begin
               w_rcnt_nxt = r_rcnt + 1'b1;
            end
`endif
         end
         ST_WAIT_LO: begin
            if (w_s2) begin
               w_state_nxt = ST_HELD;
            end else if (r_cnt == DEB_TERM) begin
               w_state_nxt   = ST_IDLE;
               w_level_nxt   = 1'b0;
               w_release_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with short debounce/repeat timing.
// Reference model: a raw input seen two edges late is accepted once it
// has differed from the current level for DEB+1 consecutive samples.
module tb_button_conditioner;

   localparam int DEB   = 4;
   localparam int RDLY  = 10;
   localparam int RPER  = 5;
   localparam int CW    = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_in = 1'b0;
   logic btn_level;
   logic btn_press;
   logic btn_release;

   int checks = 0;
   int failures = 0;

   button_conditioner #(
      .DEB_CYCLES (DEB),
      .CNT_W      (CW),
      .REP_DELAY  (RDLY),
      .REP_PERIOD (RPER)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   // Behavioural reference model
   bit m_level = 1'b0;
   bit m_press = 1'b0;
   bit m_rel   = 1'b0;
   bit m_d1    = 1'b0;
   bit m_d2    = 1'b0;
   int m_run   = 0;
   int m_held  = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
         m_d1 = 1'b0; m_d2 = 1'b0; m_run = 0; m_held = 0;
      end else begin
         bit s;
         s = m_d2;
         m_press = 1'b0;
         m_rel   = 1'b0;
         if (s != m_level) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_level = s;
               m_run   = 0;
               m_held  = 0;
               if (s) m_press = 1'b1;
               else   m_rel   = 1'b1;
            end
         end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (m_level && m_run == 0) begin
               m_held++;
               if (m_held == RDLY || (m_held > RDLY && (m_held - RDLY) % RPER == 0))
                  m_press = 1'b1;
            end
`endif
            m_run = 0;
         end
         m_d2 = m_d1;
         m_d1 = btn_in;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      btn_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold got=%b%b%b exp=000", btn_level, btn_press, btn_release);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b%b%b exp=000", btn_level, btn_press, btn_release);
         end
      end
   endtask

   task automatic test_press_latency();
      btn_in = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         checks++;
         if (btn_level !== (e >= 7) || btn_press !== (e == 7) || btn_release !== 1'b0) begin
            failures++;
            $display("FAIL press_latency edge=%0d got=%b%b%b exp=%b%b0", e,
                     btn_level, btn_press, btn_release, e >= 7, e == 7);
         end
      end
   endtask

   task automatic test_release_latency();
      btn_in = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         checks++;
         if (btn_level !== (e < 7) || btn_press !== 1'b0 || btn_release !== (e == 7)) begin
            failures++;
            $display("FAIL release_latency edge=%0d got=%b%b%b exp=%b0%b", e,
                     btn_level, btn_press, btn_release, e < 7, e == 7);
         end
      end
   endtask

   task automatic test_bounce();
      for (int p = 0; p < 4; p++) begin
         btn_in = (p % 2 == 0);
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (btn_press !== 1'b0 || btn_release !== 1'b0 || btn_level !== 1'b0) begin
               failures++;
               $display("FAIL bounce_quiet got=%b%b%b exp=000", btn_level, btn_press, btn_release);
            end
         end
      end
      btn_in = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk);
         checks++;
         if (btn_level !== (e >= 7) || btn_press !== (e == 7) || btn_release !== 1'b0) begin
            failures++;
            $display("FAIL bounce_settle edge=%0d got=%b%b%b exp=%b%b0", e,
                     btn_level, btn_press, btn_release, e >= 7, e == 7);
         end
      end
   endtask

   task automatic test_autorepeat();
      int presses;
      int exp_presses;
      btn_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_rel) begin
            failures++;
            $display("FAIL repeat_prep cyc=%0d got=%b%b%b exp=%b%b%b", i,
                     btn_level, btn_press, btn_release, m_level, m_press, m_rel);
         end
      end
      presses = 0;
      btn_in = 1'b1;
      for (int e = 1; e <= 55; e++) begin
         @(negedge clk);
         if (btn_press === 1'b1) presses++;
         checks++;
         if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_rel) begin
            failures++;
            $display("FAIL repeat_model edge=%0d got=%b%b%b exp=%b%b%b", e,
                     btn_level, btn_press, btn_release, m_level, m_press, m_rel);
         end
         if (e == 40) btn_in = 1'b0;
      end
`ifdef BTN_AUTOREPEAT_EN
      exp_presses = 7;
`else
      exp_presses = 1;
`endif
      checks++;
      if (presses !== exp_presses) begin
         failures++;
         $display("FAIL repeat_count got=%0d exp=%0d", presses, exp_presses);
      end
   endtask

   task automatic test_random();
      int left = 0;
      for (int i = 0; i < 400; i++) begin
         if (left == 0) begin
            btn_in = 1'($urandom_range(0, 1));
            left = $urandom_range(1, 12);
         end
         left--;
         @(negedge clk);
         checks++;
         if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_rel) begin
            failures++;
            $display("FAIL random cyc=%0d got=%b%b%b exp=%b%b%b", i,
                     btn_level, btn_press, btn_release, m_level, m_press, m_rel);
         end
         checks++;
         if ((btn_press & btn_release) !== 1'b0) begin
            failures++;
            $display("FAIL random_exclusive cyc=%0d got=1 exp=0", i);
         end
      end
   endtask

   task automatic test_reset_midop();
      btn_in = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_rel) begin
            failures++;
            $display("FAIL midrst_prep cyc=%0d got=%b%b%b exp=%b%b%b", i,
                     btn_level, btn_press, btn_release, m_level, m_press, m_rel);
         end
      end
      btn_in = 1'b1;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release} !== 3'b000) begin
         failures++;
         $display("FAIL midrst_async got=%b%b%b exp=000", btn_level, btn_press, btn_release);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_hold got=%b%b%b exp=000", btn_level, btn_press, btn_release);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         checks++;
         if (btn_level !== (e >= 7) || btn_press !== (e == 7) || btn_release !== 1'b0) begin
            failures++;
            $display("FAIL midrst_repress edge=%0d got=%b%b%b exp=%b%b0", e,
                     btn_level, btn_press, btn_release, e >= 7, e == 7);
         end
      end
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_release_latency();
      test_bounce();
      test_autorepeat();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
